// File: rtl/xbar_alloc_pkg.sv
// rtl/xbar_alloc_pkg.sv - shared types and destination wrap helper for the crossbar allocator
package xbar_alloc_pkg;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_e;

  // The crossbar folds out-of-range selects back by one period. A power-of-two
  // size has no out-of-range codes, so it is left alone.
  function automatic int wrap_dest(input int dest, input int n);
    if (((n & (n - 1)) != 0) && (dest >= n)) begin
      return dest - n;
    end
    return dest;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - cyclic priority picker starting at a round-robin pointer
module rr_pick #(
  parameter  int NUM_ELEM = 6,
  localparam int SEL_W    = $clog2(NUM_ELEM)
) (
  input  logic [NUM_ELEM-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                any,
  output logic [SEL_W-1:0]    idx
);

  function automatic logic [SEL_W-1:0] slot(input logic [SEL_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_ELEM) begin
      s = s - NUM_ELEM;
    end
    return SEL_W'(s);
  endfunction

  // Scanning from the far end lets the slot nearest the pointer win last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NUM_ELEM - 1; k >= 0; k--) begin
      if (req[slot(ptr, k)]) begin
        any = 1'b1;
        idx = slot(ptr, k);
      end
    end
  end

endmodule

// File: rtl/xbar_alloc.sv
// rtl/xbar_alloc.sv - packet-locked round-robin output allocator driving crossbar selects
module xbar_alloc
  import xbar_alloc_pkg::*;
#(
  parameter  int NUM_ELEM = 6,
  localparam int SEL_W    = $clog2(NUM_ELEM)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_ELEM-1:0]                in_valid_i,
  input  logic [NUM_ELEM-1:0][SEL_W-1:0]     in_dest_i,
  input  logic [NUM_ELEM-1:0]                in_last_i,
  output logic [NUM_ELEM-1:0]                in_ready_o,
  input  logic [NUM_ELEM-1:0]                out_ready_i,
  output logic [NUM_ELEM-1:0]                out_valid_o,
  output logic [NUM_ELEM-1:0][SEL_W-1:0]     sel_o,
  output logic [NUM_ELEM-1:0]                lock_o
);

  logic [NUM_ELEM-1:0][SEL_W-1:0] eff_dest;
  logic [NUM_ELEM-1:0]            cand [NUM_ELEM];
  logic [NUM_ELEM-1:0]            pick_any;
  logic [NUM_ELEM-1:0][SEL_W-1:0] pick_idx;
  logic [NUM_ELEM-1:0]            win_valid;
  logic [NUM_ELEM-1:0][SEL_W-1:0] win_idx;
  logic [NUM_ELEM-1:0]            win_last;
  logic [NUM_ELEM-1:0]            xfer;

  logic [NUM_ELEM-1:0][SEL_W-1:0] ptr_q, ptr_d;
  logic [NUM_ELEM-1:0][SEL_W-1:0] owner_q, owner_d;
  alloc_state_e                   state_q [NUM_ELEM];
  alloc_state_e                   state_d [NUM_ELEM];

  // cand[j][i]: input i has a beat for output j.
  always_comb begin
    for (int i = 0; i < NUM_ELEM; i++) begin
      eff_dest[i] = SEL_W'(wrap_dest(int'(in_dest_i[i]), NUM_ELEM));
    end
    for (int j = 0; j < NUM_ELEM; j++) begin
      cand[j] = '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
        cand[j][i] = in_valid_i[i] && (eff_dest[i] == SEL_W'(j));
      end
    end
  end

  for (genvar j = 0; j < NUM_ELEM; j++) begin : g_pick
    rr_pick #(.NUM_ELEM(NUM_ELEM)) u_pick (
      .req (cand[j]),
      .ptr (ptr_q[j]),
      .any (pick_any[j]),
      .idx (pick_idx[j])
    );
  end

  // A locked output only ever serves its owner; everyone else waits.
  always_comb begin
    win_valid = '0;
    win_idx   = '0;
    win_last  = '0;
    for (int j = 0; j < NUM_ELEM; j++) begin
      if (state_q[j] == ALLOC_LOCKED) begin
        win_valid[j] = cand[j][owner_q[j]];
        win_idx[j]   = win_valid[j] ? owner_q[j] : '0;
      end else begin
        win_valid[j] = pick_any[j];
        win_idx[j]   = pick_any[j] ? pick_idx[j] : '0;
      end
      if (rst_i) begin
        win_valid[j] = 1'b0;
        win_idx[j]   = '0;
      end
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (win_idx[j] == SEL_W'(i)) begin
          win_last[j] = in_last_i[i];
        end
      end
    end
    xfer = win_valid & out_ready_i;
  end

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    for (int j = 0; j < NUM_ELEM; j++) begin
      state_d[j] = state_q[j];
      if (xfer[j]) begin
        if (win_last[j]) begin
          state_d[j] = ALLOC_IDLE;
          ptr_d[j]   = (win_idx[j] == SEL_W'(NUM_ELEM - 1)) ? '0 : win_idx[j] + 1'b1;
        end else begin
          state_d[j] = ALLOC_LOCKED;
          owner_d[j] = win_idx[j];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      owner_q <= '0;
      for (int j = 0; j < NUM_ELEM; j++) begin
        state_q[j] <= ALLOC_IDLE;
      end
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      for (int j = 0; j < NUM_ELEM; j++) begin
        state_q[j] <= state_d[j];
      end
    end
  end

  // Each input targets one output, so at most one term below can fire.
  always_comb begin
    in_ready_o = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      for (int j = 0; j < NUM_ELEM; j++) begin
        if (xfer[j] && (win_idx[j] == SEL_W'(i))) begin
          in_ready_o[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_valid_o = win_valid;
    sel_o       = win_idx;
    for (int j = 0; j < NUM_ELEM; j++) begin
      lock_o[j] = !rst_i && (state_q[j] == ALLOC_LOCKED);
    end
  end

endmodule

// File: tb/tb_xbar_alloc.sv
// tb/tb_xbar_alloc.sv - randomized self-checking bench for xbar_alloc against a behavioural model
module tb_xbar_alloc;

  localparam int N = 6;
  localparam int W = 3;

  logic                clk;
  logic                rst;
  logic [N-1:0]        in_valid;
  logic [N-1:0][W-1:0] in_dest;
  logic [N-1:0]        in_last;
  logic [N-1:0]        in_ready_o;
  logic [N-1:0]        out_ready;
  logic [N-1:0]        out_valid_o;
  logic [N-1:0][W-1:0] sel_o;
  logic [N-1:0]        lock_o;

  int n_tests;
  int n_fail;

  int m_ptr   [N];
  int m_owner [N];
  bit m_lock  [N];

  logic [N-1:0]        e_valid;
  logic [N-1:0][W-1:0] e_sel;
  logic [N-1:0]        e_ready;
  logic [N-1:0]        e_lock;
  int                  e_win [N];

  int bg_seq [4];

  xbar_alloc #(.NUM_ELEM(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_dest_i   (in_dest),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready_o),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid_o),
    .sel_o       (sel_o),
    .lock_o      (lock_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int eff(input int d);
    return (d >= N) ? d - N : d;
  endfunction

  task automatic model_eval();
    bit found;
    int i;
    e_valid = '0;
    e_sel   = '0;
    e_ready = '0;
    e_lock  = '0;
    for (int j = 0; j < N; j++) begin
      e_win[j] = 0;
      if (!rst) begin
        e_lock[j] = m_lock[j];
        if (m_lock[j]) begin
          i = m_owner[j];
          if (in_valid[i] && eff(int'(in_dest[i])) == j) begin
            e_valid[j] = 1'b1;
            e_win[j]   = i;
          end
        end else begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            i = (m_ptr[j] + k) % N;
            if (!found && in_valid[i] && eff(int'(in_dest[i])) == j) begin
              found      = 1'b1;
              e_valid[j] = 1'b1;
              e_win[j]   = i;
            end
          end
        end
        e_sel[j] = W'(e_win[j]);
      end
    end
    for (int ii = 0; ii < N; ii++) begin
      int d;
      d = eff(int'(in_dest[ii]));
      if (!rst && e_valid[d] && e_win[d] == ii && out_ready[d]) e_ready[ii] = 1'b1;
    end
  endtask

  task automatic model_update();
    for (int j = 0; j < N; j++) begin
      if (rst) begin
        m_ptr[j]   = 0;
        m_owner[j] = 0;
        m_lock[j]  = 1'b0;
      end else if (e_valid[j] && out_ready[j]) begin
        if (in_last[e_win[j]]) begin
          m_lock[j] = 1'b0;
          m_ptr[j]  = (e_win[j] + 1) % N;
        end else begin
          m_lock[j]  = 1'b1;
          m_owner[j] = e_win[j];
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    check("out_valid", 32'(out_valid_o), 32'(e_valid));
    check("sel", 32'(sel_o), 32'(e_sel));
    check("in_ready", 32'(in_ready_o), 32'(e_ready));
    check("lock", 32'(lock_o), 32'(e_lock));
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    bg_seq    = '{0, 2, 4, 0};
    for (int j = 0; j < N; j++) begin
      m_ptr[j] = 0; m_owner[j] = 0; m_lock[j] = 1'b0;
    end
    rst       = 1'b1;
    in_valid  = '0;
    in_dest   = '0;
    in_last   = '0;
    out_ready = '0;
    step();
    check("rst_valid", 32'(out_valid_o), 32'h0);
    adv();

    rst       = 1'b0;
    in_valid  = 6'b010101;
    for (int i = 0; i < N; i++) in_dest[i] = 3'd3;
    in_last   = '1;
    out_ready = '1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("bg_sel3", 32'(sel_o[3]), 32'(bg_seq[k]));
      adv();
    end

    in_valid   = 6'b000010;
    in_dest[1] = 3'd7;
    step();
    check("wrap_sel1", 32'(sel_o[1]), 32'd1);
    check("wrap_valid1", 32'(out_valid_o[1]), 32'd1);
    adv();

    in_valid = '1;
    for (int i = 0; i < N; i++) in_dest[i] = W'(N - 1 - i);
    step();
    check("par_ready", 32'(in_ready_o), 32'h3f);
    check("par_sel", 32'(sel_o), 32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5}));
    adv();

    in_valid  = 6'b000100;
    in_dest   = '0;
    in_dest[2] = 3'd4;
    in_last   = '0;
    step();
    adv();
    in_valid  = 6'b001100;
    in_dest[3] = 3'd4;
    step();
    check("pk_lock4", 32'(lock_o[4]), 32'd1);
    check("pk_sel4", 32'(sel_o[4]), 32'd2);
    adv();

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 60) == 0);
      for (int i = 0; i < N; i++) begin
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        in_dest[i]   = W'($urandom_range(0, 7));
        in_last[i]   = ($urandom_range(0, 2) == 0);
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      step();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
